// File: rtl/softmax_div_pkg.sv
// rtl/softmax_div_pkg.sv - shared types and helpers for the softmax pipelined divider
package softmax_div_pkg;

  // Widest operand the magnitude helpers handle; callers cast in and out of this width.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic valid;
    logic sign_q;
    logic sign_r;
    logic dz;
  } stage_flags_t;

  function automatic int num_stages(input int a_width, input int bits_per_stage);
    if (bits_per_stage <= 0) return a_width;
    return (a_width + bits_per_stage - 1) / bits_per_stage;
  endfunction

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic is_neg);
    return cond_negate(x, is_neg);
  endfunction

  function automatic logic [MAX_W-1:0] sign_fixup(input logic [MAX_W-1:0] mag, input logic neg);
    return cond_negate(mag, neg);
  endfunction

endpackage

// File: rtl/softmax_div_stage.sv
// rtl/softmax_div_stage.sv - one restoring-division stage resolving BITS_PER_STAGE quotient bits
module softmax_div_stage
  import softmax_div_pkg::*;
#(
  parameter int A_WIDTH        = 64,
  parameter int B_WIDTH        = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  input  stage_flags_t         in_flags,
  input  logic [B_WIDTH:0]     in_rem,
  input  logic [A_WIDTH-1:0]   in_quo,
  input  logic [B_WIDTH-1:0]   in_dvs,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output stage_flags_t         out_flags,
  output logic [B_WIDTH:0]     out_rem,
  output logic [A_WIDTH-1:0]   out_quo,
  output logic [B_WIDTH-1:0]   out_dvs,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic [B_WIDTH:0]   rem_c;
  logic [A_WIDTH-1:0] quo_c;

  // quo starts as the dividend magnitude: its MSB feeds the remainder and quotient bits enter at the LSB.
  always_comb begin
    rem_c = in_rem;
    quo_c = in_quo;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      rem_c = {rem_c[B_WIDTH-1:0], quo_c[A_WIDTH-1]};
      quo_c = {quo_c[A_WIDTH-2:0], 1'b0};
      if (rem_c >= {1'b0, in_dvs}) begin
        rem_c    = rem_c - {1'b0, in_dvs};
        quo_c[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags <= '0;
    end else if (adv) begin
      out_flags <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      out_rem <= rem_c;
      out_quo <= quo_c;
      out_dvs <= in_dvs;
      out_tag <= in_tag;
    end
  end

endmodule

// File: rtl/softmax_div_pipe.sv
// rtl/softmax_div_pipe.sv - pipelined restoring divider top; SOFTMAX_DIV_ROUND_EN selects round-to-nearest
module softmax_div_pipe
  import softmax_div_pkg::*;
#(
  parameter int A_WIDTH        = 64,
  parameter int B_WIDTH        = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TC_MODE        = 0,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_WIDTH-1:0]   quotient,
  output logic [B_WIDTH-1:0]   remainder,
  output logic                 div_by_0,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int S = num_stages(A_WIDTH, BITS_PER_STAGE);

  logic               adv;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;

  stage_flags_t         in_flags_q;
  logic [A_WIDTH-1:0]   in_quo_q;
  logic [B_WIDTH-1:0]   in_dvs_q;
  logic [TAG_WIDTH-1:0] in_tag_q;

  stage_flags_t         flags [0:S];
  logic [B_WIDTH:0]     rem   [0:S];
  logic [A_WIDTH-1:0]   quo   [0:S];
  logic [B_WIDTH-1:0]   dvs   [0:S];
  logic [TAG_WIDTH-1:0] tag   [0:S];

  logic [A_WIDTH-1:0] q_mag;
  logic [A_WIDTH-1:0] q_res;
  logic [B_WIDTH-1:0] r_mag;
  logic [B_WIDTH-1:0] r_res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign sign_a = (TC_MODE != 0) && a[A_WIDTH-1];
  assign sign_b = (TC_MODE != 0) && b[B_WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = A_WIDTH'(abs_val(MAX_W'(a), sign_a));
  assign b_mag  = B_WIDTH'(abs_val(MAX_W'(b), sign_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flags_q <= '0;
    end else if (adv) begin
      in_flags_q <= '{valid: in_valid, sign_q: sign_a ^ sign_b, sign_r: sign_a, dz: b_zero};
    end
  end

  // A zero divisor never needs its divisor slot, so it carries a[B_WIDTH-1:0] to the output as the remainder.
  always_ff @(posedge clk) begin
    if (adv) begin
      in_quo_q <= a_mag;
      in_dvs_q <= b_zero ? a[B_WIDTH-1:0] : b_mag;
      in_tag_q <= in_tag;
    end
  end

  assign flags[0] = in_flags_q;
  assign rem[0]   = '0;
  assign quo[0]   = in_quo_q;
  assign dvs[0]   = in_dvs_q;
  assign tag[0]   = in_tag_q;

  for (genvar g = 0; g < S; g++) begin : g_stage
    softmax_div_stage #(
      .A_WIDTH       (A_WIDTH),
      .B_WIDTH       (B_WIDTH),
      .BITS_PER_STAGE(BITS_PER_STAGE),
      .TAG_WIDTH     (TAG_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .in_flags (flags[g]),
      .in_rem   (rem[g]),
      .in_quo   (quo[g]),
      .in_dvs   (dvs[g]),
      .in_tag   (tag[g]),
      .out_flags(flags[g+1]),
      .out_rem  (rem[g+1]),
      .out_quo  (quo[g+1]),
      .out_dvs  (dvs[g+1]),
      .out_tag  (tag[g+1])
    );
  end

`ifdef SOFTMAX_DIV_ROUND_EN
  logic [A_WIDTH-1:0] q_max;

  // Largest magnitude representable with the result's sign; rounding never steps past it.
  assign q_max = flags[S].sign_q ? {1'b1, {(A_WIDTH-1){1'b0}}} :
                 (TC_MODE != 0)  ? {1'b0, {(A_WIDTH-1){1'b1}}} : {A_WIDTH{1'b1}};
`endif

  always_comb begin
    q_mag = quo[S];
    r_mag = B_WIDTH'(rem[S]);
`ifdef SOFTMAX_DIV_ROUND_EN
    if (!flags[S].dz && ({r_mag, 1'b0} >= {1'b0, dvs[S]}) && (q_mag < q_max)) begin
      q_mag = q_mag + A_WIDTH'(1);
    end
`endif
    q_res = A_WIDTH'(sign_fixup(MAX_W'(q_mag), flags[S].sign_q));
    r_res = B_WIDTH'(sign_fixup(MAX_W'(r_mag), flags[S].sign_r));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_by_0  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= flags[S].valid;
      quotient  <= flags[S].dz ? '1 : q_res;
      remainder <= flags[S].dz ? dvs[S] : r_res;
      div_by_0  <= flags[S].valid && flags[S].dz;
      out_tag   <= tag[S];
    end
  end

endmodule

// File: tb/tb_softmax_div_pipe.sv
// tb/tb_softmax_div_pipe.sv - directed bench for softmax_div_pipe (honours SOFTMAX_DIV_ROUND_EN)
module tb_softmax_div_pipe;

`ifdef SOFTMAX_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [63:0] qr;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [63:0] aa = '0;
  logic [31:0] ba = '0;
  logic [7:0]  ta = '0;

  logic        ir0, ov0, dz0, ir1, ov1, dz1, ir2, ov2, dz2;
  logic [63:0] q0;
  logic [31:0] r0, q1, q2;
  logic [15:0] r1, r2;
  logic [7:0]  t0, t1, t2;

  logic        ov_m, ir_m, dz_m;
  logic [63:0] q_m;
  logic [31:0] r_m;
  logic [7:0]  tag_m;

  assign ov_m  = (sel == 2'd0) ? ov0 : (sel == 2'd1) ? ov1 : ov2;
  assign ir_m  = (sel == 2'd0) ? ir0 : (sel == 2'd1) ? ir1 : ir2;
  assign dz_m  = (sel == 2'd0) ? dz0 : (sel == 2'd1) ? dz1 : dz2;
  assign q_m   = (sel == 2'd0) ? q0 : (sel == 2'd1) ? {32'b0, q1} : {32'b0, q2};
  assign r_m   = (sel == 2'd0) ? r0 : (sel == 2'd1) ? {16'b0, r1} : {16'b0, r2};
  assign tag_m = (sel == 2'd0) ? t0 : (sel == 2'd1) ? t1 : t2;

  softmax_div_pipe u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd0), .in_ready(ir0),
    .a(aa), .b(ba), .in_tag(ta), .out_valid(ov0), .out_ready(ordy || sel != 2'd0),
    .quotient(q0), .remainder(r0), .div_by_0(dz0), .out_tag(t0)
  );

  softmax_div_pipe #(.A_WIDTH(32), .B_WIDTH(16), .BITS_PER_STAGE(2), .TC_MODE(1), .TAG_WIDTH(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd1), .in_ready(ir1),
    .a(aa[31:0]), .b(ba[15:0]), .in_tag(ta), .out_valid(ov1), .out_ready(ordy || sel != 2'd1),
    .quotient(q1), .remainder(r1), .div_by_0(dz1), .out_tag(t1)
  );

  softmax_div_pipe #(.A_WIDTH(32), .B_WIDTH(16), .BITS_PER_STAGE(4), .TC_MODE(0), .TAG_WIDTH(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd2), .in_ready(ir2),
    .a(aa[31:0]), .b(ba[15:0]), .in_tag(ta), .out_valid(ov2), .out_ready(ordy || sel != 2'd2),
    .quotient(q2), .remainder(r2), .div_by_0(dz2), .out_tag(t2)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [63:0] a, input logic [31:0] b, input logic [63:0] q,
                         input logic [63:0] qr, input logic [31:0] r, input logic dz);
    tv.push_back('{a, b, q, qr, r, dz});
  endtask

  // Called #1 after a rising edge; n counts edges until out_valid is seen.
  task automatic latency(input string name, input logic [63:0] a, input logic [31:0] b,
                         input logic [7:0] t, input int exp_lat);
    int n;
    iv = 1'b1; aa = a; ba = b; ta = t; ordy = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) iv = 1'b0;
    end while (!ov_m && n < 200);
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_stream(input string name, input bit rand_rdy);
    int          sent, got, cyc;
    bit          stalled, acc;
    logic [63:0] hq;
    logic [7:0]  ht;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; hq = '0; ht = '0;
    while (got < tv.size() && cyc < 3000) begin
      iv = (sent < tv.size());
      if (iv) begin
        aa = tv[sent].a; ba = tv[sent].b; ta = 8'(sent);
      end
      ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        chk({name, " stall_valid"}, 64'(ov_m), 64'd1);
        chk({name, " stall_q"}, q_m, hq);
        chk({name, " stall_tag"}, 64'(tag_m), 64'(ht));
      end
      stalled = ov_m && !ordy;
      hq = q_m; ht = tag_m;
      if (ov_m && ordy) begin
        chk($sformatf("%s[%0d] q", name, got), q_m, ROUND ? tv[got].qr : tv[got].q);
        chk($sformatf("%s[%0d] r", name, got), 64'(r_m), 64'(tv[got].r));
        chk($sformatf("%s[%0d] dz", name, got), 64'(dz_m), 64'(tv[got].dz));
        chk($sformatf("%s[%0d] tag", name, got), 64'(tag_m), 64'(8'(got)));
        got++;
      end
      acc = iv && ir_m;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    iv = 1'b0; ordy = 1'b1;
    chk({name, " count"}, 64'(got), 64'(tv.size()));
  endtask

  initial begin
    logic [63:0] ma, mq, mr, mqr;
    logic [31:0] mb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(ov_m), 64'd0);
    chk("rst in_ready", 64'(ir_m), 64'd1);
    chk("rst quotient", q_m, 64'd0);
    chk("rst remainder", 64'(r_m), 64'd0);
    chk("rst div_by_0", 64'(dz_m), 64'd0);
    chk("rst out_tag", 64'(tag_m), 64'd0);
    chk("rst ov1", 64'(ov1), 64'd0);
    chk("rst ov2", 64'(ov2), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 2'd0;
    latency("d0 100/7", 64'd100, 32'd7, 8'h5A, 66);
    chk("d0 100/7 q", q_m, 64'd14);
    chk("d0 100/7 r", 64'(r_m), 64'd2);
    chk("d0 100/7 dz", 64'(dz_m), 64'd0);
    chk("d0 100/7 tag", 64'(tag_m), 64'h5A);
    repeat (3) @(posedge clk);
    #1;

    tv.delete();
    add_vec(64'd100, 32'd7, 64'd14, 64'd14, 32'd2, 1'b0);
    add_vec(64'h1234, 32'd0, '1, '1, 32'h1234, 1'b1);
    add_vec('1, 32'd1, '1, '1, 32'd0, 1'b0);
    add_vec(64'd0, 32'd5, 64'd0, 64'd0, 32'd0, 1'b0);
    add_vec(64'd3, 32'd10, 64'd0, 64'd0, 32'd3, 1'b0);
    add_vec(64'd15, 32'd4, 64'd3, 64'd4, 32'd3, 1'b0);
    add_vec(64'd13, 32'd4, 64'd3, 64'd3, 32'd1, 1'b0);
    add_vec('1, 32'hFFFF_FFFF, 64'h1_0000_0001, 64'h1_0000_0001, 32'd0, 1'b0);
    add_vec(64'h8000_0000_0000_0000, 32'h8000_0000, 64'h1_0000_0000, 64'h1_0000_0000, 32'd0, 1'b0);
    add_vec(64'h1_0000_0005, 32'd3, 64'h5555_5557, 64'h5555_5557, 32'd0, 1'b0);
    add_vec(64'hDEAD_BEEF_CAFE_F00D, 32'd0, '1, '1, 32'hCAFE_F00D, 1'b1);
    add_vec(64'd1000, 32'hFFFF_FFFF, 64'd0, 64'd0, 32'd1000, 1'b0);
    run_stream("d0", 1'b0);
    repeat (3) @(posedge clk);
    #1;

    sel = 2'd1;
    tv.delete();
    add_vec(64'hFFFF_FFF9, 32'h0002, 64'hFFFF_FFFD, 64'hFFFF_FFFC, 32'hFFFF, 1'b0);
    add_vec(64'h8000_0000, 32'hFFFF, 64'h8000_0000, 64'h8000_0000, 32'h0, 1'b0);
    add_vec(64'h7, 32'hFFFE, 64'hFFFF_FFFD, 64'hFFFF_FFFC, 32'h1, 1'b0);
    add_vec(64'hFFFF_FFF8, 32'hFFFD, 64'h2, 64'h3, 32'hFFFE, 1'b0);
    add_vec(64'd100, 32'd7, 64'd14, 64'd14, 32'd2, 1'b0);
    add_vec(64'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFB, 1'b1);
    add_vec(64'h8000_0000, 32'h1, 64'h8000_0000, 64'h8000_0000, 32'h0, 1'b0);
    add_vec(64'h7FFF_FFFF, 32'hFFFF, 64'h8000_0001, 64'h8000_0001, 32'h0, 1'b0);
    add_vec(64'hFFFF_FFFF, 32'h7FFF, 64'h0, 64'h0, 32'hFFFF, 1'b0);
    add_vec(64'h8000_0000, 32'h8000, 64'h0001_0000, 64'h0001_0000, 32'h0, 1'b0);
    run_stream("d1", 1'b0);
    repeat (3) @(posedge clk);
    #1;

    sel = 2'd2;
    tv.delete();
    for (int i = 0; i < 20; i++) begin
      ma = 64'(i * 37771 + 999);
      mb = (i == 7) ? 32'd0 : 32'(i % 9 + 2);
      if (mb == 0) begin
        mq = 64'hFFFF_FFFF; mr = {48'b0, ma[15:0]}; mqr = mq;
      end else begin
        mq = ma / 64'(mb); mr = ma % 64'(mb);
        mqr = (2 * mr >= 64'(mb) && mq != 64'hFFFF_FFFF) ? mq + 1 : mq;
      end
      add_vec(ma, mb, mq, mqr, mr[31:0], mb == 0);
    end
    run_stream("d2 bp", 1'b1);
    repeat (3) @(posedge clk);
    #1;

    iv = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      aa = 64'(i * 3 + 50); ba = 32'd5; ta = 8'(i);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    chk("d2 pre-reset out_valid", 64'(ov_m), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("d2 reset out_valid", 64'(ov_m), 64'd0);
    chk("d2 reset in_ready", 64'(ir_m), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    latency("d2 post-reset", 64'd77, 32'd7, 8'hEE, 10);
    chk("d2 post-reset tag", 64'(tag_m), 64'hEE);
    chk("d2 post-reset q", q_m, 64'd11);
    chk("d2 post-reset r", 64'(r_m), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
